// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_unit
//  Purpose  : Sequential ALU with registered CF/SF/ZF/OF flags, ADC/SBB carry
//             chaining and a WIDTH-cycle shift-add multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cf,
    output logic             sf,
    output logic             zf,
    output logic             of
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 done_q, done_d;
    logic                 cf_q, cf_d, sf_q, sf_d, zf_q, zf_d, of_q, of_d;

    logic                 w_cin;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [WIDTH-1:0]     w_r;
    logic                 w_c;
    logic                 w_o;
    logic [WIDTH:0]       w_step_hi;
    logic [2*WIDTH-1:0]   w_prod_next;

    assign w_cin = ((op == OP_ADC) || (op == OP_SBB)) ? cf_q : 1'b0;
    assign w_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
    // Bit WIDTH of the extended difference is set exactly when a < b + borrow-in.
    assign w_sub = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_r = '0;
        w_c = 1'b0;
        w_o = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                w_r = w_add[WIDTH-1:0];
                w_c = w_add[WIDTH];
                w_o = (a[WIDTH-1] == b[WIDTH-1]) && (w_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                w_r = w_sub[WIDTH-1:0];
                w_c = w_sub[WIDTH];
                w_o = (a[WIDTH-1] != b[WIDTH-1]) && (w_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_r = a & b;
            OP_OR:   w_r = a | b;
            OP_XOR:  w_r = a ^ b;
            default: w_r = '0;
        endcase
    end

    // Multiplier in low half of prod_q shifts out as product bits shift in.
    assign w_step_hi   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                       + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign w_prod_next = {w_step_hi, prod_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        done_d      = 1'b0;
        cf_d        = cf_q;
        sf_d        = sf_q;
        zf_d        = zf_q;
        of_d        = of_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_d = a;
                        prod_d  = {{WIDTH{1'b0}}, b};
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        result_d    = w_r;
                        result_hi_d = '0;
                        done_d      = 1'b1;
                        cf_d        = w_c;
                        of_d        = w_o;
                        sf_d        = w_r[WIDTH-1];
                        zf_d        = (w_r == '0);
                    end
                end
            end
            S_MUL: begin
                prod_d = w_prod_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    result_d    = w_prod_next[WIDTH-1:0];
                    result_hi_d = w_prod_next[2*WIDTH-1:WIDTH];
                    cf_d        = (w_prod_next[2*WIDTH-1:WIDTH] != '0);
                    of_d        = (w_prod_next[2*WIDTH-1:WIDTH] != '0);
                    sf_d        = w_prod_next[2*WIDTH-1];
                    zf_d        = (w_prod_next == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            done_q      <= 1'b0;
            cf_q        <= 1'b0;
            sf_q        <= 1'b0;
            zf_q        <= 1'b0;
            of_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            done_q      <= done_d;
            cf_q        <= cf_d;
            sf_q        <= sf_d;
            zf_q        <= zf_d;
            of_q        <= of_d;
        end
    end

    assign busy      = (state_q == S_MUL);
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign cf        = cf_q;
    assign sf        = sf_q;
    assign zf        = zf_q;
    assign of        = of_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_unit
//  Purpose  : Directed self-checking bench for alu_seq_unit (WIDTH=6) using a
//             reference model feeding an expected-result queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    localparam int W = 6;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ADC = 3'd2, SBB = 3'd3;
    localparam logic [2:0] AND = 3'd4, OR  = 3'd5, XOR = 3'd6, MUL = 3'd7;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic         cf;
        logic         sf;
        logic         zf;
        logic         of;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result, result_hi;
    logic         cf, sf, zf, of;

    int    n_vec = 0;
    int    n_err = 0;
    logic  m_cf  = 1'b0;
    exp_t  sb[$];
    exp_t  last;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .cf        (cf),
        .sf        (sf),
        .zf        (zf),
        .of        (of)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic cin);
        exp_t e;
        int   s;
        int   bw;
        e  = '0;
        bw = 0;
        case (o)
            ADD, ADC: begin
                if (o == ADC) bw = int'(cin);
                s    = int'(x) + int'(y) + bw;
                e.r  = s[W-1:0];
                e.cf = s[W];
                e.of = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
            end
            SUB, SBB: begin
                if (o == SBB) bw = int'(cin);
                s    = int'(x) - int'(y) - bw;
                e.r  = s[W-1:0];
                e.cf = (int'(x) < int'(y) + bw);
                e.of = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
            end
            AND: e.r = x & y;
            OR:  e.r = x | y;
            XOR: e.r = x ^ y;
            default: begin
                s    = int'(x) * int'(y);
                e.r  = s[W-1:0];
                e.hi = s[2*W-1:W];
                e.cf = (e.hi != '0);
                e.of = (e.hi != '0);
                e.sf = e.hi[W-1];
                e.zf = (s == 0);
            end
        endcase
        if (o != MUL) begin
            e.sf = e.r[W-1];
            e.zf = (e.r == '0);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e     = model(o, x, y, m_cf);
        m_cf  = e.cf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        check({tag, "_sb"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e    = sb.pop_front();
            last = e;
            check({tag, "_result"}, 32'(result), 32'(e.r));
            check({tag, "_hi"},     32'(result_hi), 32'(e.hi));
            check({tag, "_flags"},  32'({cf, sf, zf, of}), 32'({e.cf, e.sf, e.zf, e.of}));
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        drive(o, x, y);
        check({tag, "_busy_done"}, 32'({busy, done}), 32'b01);
        compare(tag);
    endtask

    // inject > 0: an ADD start is presented just before edge k+inject.
    task automatic run_mul(input string tag, input logic [W-1:0] x,
                           input logic [W-1:0] y, input int inject);
        drive(MUL, x, y);
        check({tag, "_busy0"}, 32'({busy, done}), 32'b10);
        for (int i = 1; i <= W; i++) begin
            if (i == inject) begin
                start = 1'b1;
                op    = ADD;
                a     = 6'b000111;
                b     = 6'b000001;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i < W) check({tag, "_wait"}, 32'({busy, done}), 32'b10);
            else       check({tag, "_end"},  32'({busy, done}), 32'b01);
        end
        compare(tag);
    endtask

    task automatic check_held(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'({busy, done}), 32'b00);
        check({tag, "_held"},  32'({result_hi, result, cf, sf, zf, of}),
              32'({last.hi, last.r, last.cf, last.sf, last.zf, last.of}));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = ADD;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 32'({busy, done, result_hi, result, cf, sf, zf, of}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_ovf", ADD, 6'b010101, 6'b001100);
        check_held("add_ovf");
        run_op("add_wrap", ADD, 6'b111111, 6'b000001);
        run_op("adc_cin", ADC, 6'b000001, 6'b000001);
        run_op("sub_borrow", SUB, 6'b000011, 6'b000101);
        run_op("sbb_bin", SBB, 6'b001010, 6'b000011);
        run_op("sub_ovf", SUB, 6'b100000, 6'b000001);
        run_op("and", AND, 6'b110101, 6'b011100);
        run_op("or", OR, 6'b100001, 6'b000110);
        run_op("xor_zero", XOR, 6'b101101, 6'b101101);
        run_op("add_b2b", ADD, 6'b011111, 6'b000001);

        run_mul("mul_max", 6'b111111, 6'b111111, 2);
        check_held("mul_max");
        run_mul("mul_zero", 6'b000000, 6'b101010, 0);
        run_mul("mul_mid", 6'b001101, 6'b010110, 0);
        run_op("add_after_mul", ADD, 6'b000001, 6'b000010);

        run_op("pre_rst_sub", SUB, 6'b000011, 6'b000101);
        drive(MUL, 6'b111111, 6'b111111);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'({busy, done, result_hi, result, cf, sf, zf, of}), 32'd0);
        sb.delete();
        m_cf = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold", 32'({busy, done}), 32'b00);
        @(negedge clk);
        rst = 1'b0;
        run_op("add_post_rst", ADD, 6'b000010, 6'b000011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
